// File: rtl/uart_rx_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_param : oversampled mid-bit UART receiver with valid/ready output,
// framing/overrun/parity errors. Parity check compiled in by UART_RX_PARITY_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 sample_tick,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] c_half_m1  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] c_last_smp = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] c_last_bit = BW'(DATA_BITS - 1);
  localparam logic          c_last_stp = 1'(STOP_BITS - 1);
  localparam logic          c_par_odd  = (PARITY_ODD != 0);

  if ((DATA_BITS < 5) || (DATA_BITS > 9) || (OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0) ||
      (STOP_BITS < 1) || (STOP_BITS > 2) || (c_par_odd != PARITY_ODD[0])) begin : g_bad_params
    $error("uart_rx_param: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                 state_q, state_d;
  logic                   sin_meta_q, sin_s_q;
  logic [SW-1:0]          sample_cnt_q, sample_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   ferr_q, ferr_d;
  logic                   perr_q, perr_d;
  logic                   done_q, done_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_err_q, overrun_err_d;
  logic                   parity_err_q, parity_err_d;

  always_comb begin
    state_d       = state_q;
    sample_cnt_d  = sample_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    stop_cnt_d    = stop_cnt_q;
    shift_d       = shift_q;
    ferr_d        = ferr_q;
    perr_d        = perr_q;
    done_d        = 1'b0;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    parity_err_d  = 1'b0;

    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!sin_s_q) begin
            state_d      = START;
            sample_cnt_d = '0;
          end
        end
        START: begin
          if (sample_cnt_q == c_half_m1) begin
            if (sin_s_q) begin
              state_d = IDLE;
            end else begin
              state_d      = DATA;
              sample_cnt_d = '0;
              bit_cnt_d    = '0;
              stop_cnt_d   = 1'b0;
              ferr_d       = 1'b0;
              perr_d       = 1'b0;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
          end
        end
        DATA: begin
          if (sample_cnt_q == c_last_smp) begin
            sample_cnt_d = '0;
            shift_d      = {sin_s_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_d    = bit_cnt_q + BW'(1);
            if (bit_cnt_q == c_last_bit) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample_cnt_q == c_last_smp) begin
            sample_cnt_d = '0;
            perr_d       = sin_s_q ^ (^shift_q) ^ c_par_odd;
            state_d      = STOP;
          end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
          end
        end
`endif
        STOP: begin
          if (sample_cnt_q == c_last_smp) begin
            sample_cnt_d = '0;
            if (!sin_s_q) ferr_d = 1'b1;
            if (stop_cnt_q == c_last_stp) begin
              done_d  = 1'b1;
              // A low stop bit may be a break: wait for the line to go idle.
              state_d = (ferr_q || !sin_s_q) ? WAIT_HIGH : IDLE;
            end else begin
              stop_cnt_d = stop_cnt_q + 1'b1;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
          end
        end
        WAIT_HIGH: begin
          if (sin_s_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    // Frame-level errors take priority and suppress the overrun check.
    if (done_q) begin
      if (ferr_q) begin
        frame_err_d = 1'b1;
      end else if (perr_q) begin
        parity_err_d = 1'b1;
      end else if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sin_meta_q    <= 1'b1;
      sin_s_q       <= 1'b1;
      state_q       <= IDLE;
      sample_cnt_q  <= '0;
      bit_cnt_q     <= '0;
      stop_cnt_q    <= 1'b0;
      shift_q       <= '0;
      ferr_q        <= 1'b0;
      perr_q        <= 1'b0;
      done_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      sin_meta_q    <= serial_in;
      sin_s_q       <= sin_meta_q;
      state_q       <= state_d;
      sample_cnt_q  <= sample_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      stop_cnt_q    <= stop_cnt_d;
      shift_q       <= shift_d;
      ferr_q        <= ferr_d;
      perr_q        <= perr_d;
      done_q        <= done_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      parity_err_q  <= parity_err_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign parity_err  = parity_err_q;
  assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver: oversampled, mid-bit sampled, configurable data width and stop-bit count.
Adds a valid/ready output handshake, framing and overrun detection, and false-start rejection. Optional parity checking is compiled in by macro.
Sits between the pad-side serial line and the host interface. Driven by a single system clock with a baud-rate sample-tick enable.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
OVERSAMPLE, 16, sample ticks per bit, even, >=4
STOP_BITS, 1, stop bits checked per frame, 1 or 2
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_RX_PARITY_EN is defined

Ports:
clk  input  1  system clock, rising edge
reset_  input  1  asynchronous active-low reset
sample_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate
serial_in  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received word, valid while rx_valid=1
rx_valid  output  1  rx_data holds an unconsumed word
rx_ready  input  1  host accepts the word on a cycle where rx_valid=1 and rx_ready=1
frame_err  output  1  one-clk pulse: a stop bit was sampled low
overrun_err  output  1  one-clk pulse: a good frame was dropped because the holding register was full
parity_err  output  1  one-clk pulse: parity mismatch (constant 0 without the macro)
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async): state=IDLE, counters=0, shift register=0, rx_data=0, rx_valid=0, all error pulses 0, busy=0. Both synchroniser flops reset to 1.
- serial_in passes through a 2-flop synchroniser, giving sin_s. All FSM decisions use sin_s.
- The FSM and counters advance only on clk edges where sample_tick=1. With sample_tick held 0, everything freezes; the output handshake still operates every clk.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: sin_s=0 on a tick -> START, sample_cnt=0.
- START: increment sample_cnt each tick. At sample_cnt==OVERSAMPLE/2-1, check sin_s:
  - sin_s=1: false start -> IDLE. No error flagged.
  - sin_s=0: clear sample_cnt, bit_cnt=0 -> DATA.
- DATA: at sample_cnt==OVERSAMPLE-1, shift sin_s into the MSB end (LSB-first frame), increment bit_cnt, clear sample_cnt. After bit DATA_BITS: -> PARITY if macro defined, else -> STOP.
- PARITY: one bit period. At sample_cnt==OVERSAMPLE-1, latch parity mismatch -> STOP.
- STOP: sample each of STOP_BITS bits at sample_cnt==OVERSAMPLE-1. Any stop bit low marks a frame error.
  - After the last stop bit, complete the frame.
  - Next state is WAIT_HIGH if a frame error occurred, else IDLE.
- WAIT_HIGH: stay until sin_s=1 on a tick, then -> IDLE. A break condition therefore does not retrigger reception.
- Frame completion, one clk after the final stop-sample tick:
  - frame error: pulse frame_err, discard the data.
  - parity error (macro only): pulse parity_err, discard the data.
  - good frame with rx_valid=0: load rx_data, set rx_valid.
  - good frame with rx_valid=1 and rx_ready=1 in the same cycle: load the new word; rx_valid stays 1.
  - good frame with rx_valid=1 and rx_ready=0: pulse overrun_err, drop the new word, keep the old word.
- Any frame-level error suppresses the overrun check for that frame.
- Handshake: rx_valid clears on the clk after rx_valid and rx_ready are both high. rx_ready is ignored while rx_valid=0.
- Latency: rx_valid rises about 2 clk after the tick that samples the last stop bit (1 synchroniser-adjusted cycle plus 1 register cycle).
- Width rules:
  - sample_cnt is clog2(OVERSAMPLE) bits.
  - bit_cnt is clog2(DATA_BITS+1) bits.
  - Counters never wrap inside a frame; they are cleared at each bit boundary.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is lost with no error pulse.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: a PARITY bit follows the data bits.
- The expected parity is the XOR of the data bits, inverted if PARITY_ODD=1.
- On mismatch: parity_err pulses, the word is discarded, the FSM continues to STOP.
- Undefined: no PARITY state, parity_err tied 0, frame = start + DATA_BITS + STOP_BITS.

Test Plan:
- Defaults, 0xA5 sent at 16 ticks/bit, rx_ready=1 -> rx_data=0xA5, rx_valid high exactly 1 clk; no errors.
- Line low for 4 ticks then high -> state returns to IDLE, busy drops, no rx_valid, no error pulses.
- 0x3C with stop bit 0, line held low 40 ticks then high -> frame_err pulse once, rx_valid stays 0, no new start until the line has been high; a following 0x11 is received correctly.
- rx_ready=0, send 0x12 then 0x34 -> rx_valid=1, rx_data=0x12, overrun_err pulses once at the 0x34 completion. Then rx_ready=1 for 1 clk -> rx_valid=0.
- STOP_BITS=2, DATA_BITS=7, 0x55 with second stop bit 0 -> frame_err.
- Macro on, PARITY_ODD=0: 0x03 with parity bit 1 -> parity_err, rx_valid stays 0; 0x03 with parity bit 0 -> rx_data=0x03.
- Reset_ low in the middle of the DATA bits of 0xFF -> all outputs 0 immediately; a following 0x81 is received correctly.
